// File: rtl/outflow_ctrl_pkg.sv
// Shared definitions for the outflow (drain-side) ping-pong buffer sequencer.
package outflow_ctrl_pkg;

  // FSM state encoding
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_DRAIN = 1'b1;

  // Buffer indices
  localparam logic BUF0 = 1'b0;
  localparam logic BUF1 = 1'b1;

  // One-hot mask selecting the per-buffer bit for a buffer index
  function automatic logic [1:0] buf_onehot(input logic sel);
    logic [1:0] mask;
    case (sel)
      BUF0:    mask = 2'b01;
      BUF1:    mask = 2'b10;
      default: mask = 2'b00;
    endcase
    return mask;
  endfunction

endpackage

// File: rtl/outflow_ctrl_drain_timer.sv
// Drain watchdog: loadable saturating up-counter with a terminal-count flag.
// The flag never fires when TIMEOUT_CYCLES is 0.
module outflow_ctrl_drain_timer #(
  parameter int TIMEOUT_CYCLES = 0
) (
  input  logic clk,
  input  logic resetn,
  input  logic load_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int             TW     = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0]  TC_VAL = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]  SAT    = {TW{1'b1}};
  localparam logic           TO_EN  = (TIMEOUT_CYCLES != 0);

  logic [TW-1:0] timer_q;
  logic [TW-1:0] timer_d;

  // Next count: clear on load, otherwise count while enabled until saturated
  always_comb begin
    timer_d = timer_q;
    if (load_i) begin
      timer_d = {TW{1'b0}};
    end else if (en_i && (timer_q != SAT)) begin
      timer_d = timer_q + TW'(1);
    end else begin
      timer_d = timer_q;
    end
  end

  // Counter register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!resetn) begin
      timer_q <= {TW{1'b0}};
    end else begin
      timer_q <= timer_d;
    end
  end

  assign tc_o = TO_EN & en_i & (timer_q == TC_VAL);

endmodule

// File: rtl/outflow_ctrl.sv
// Drain-side sequencer for the two ping-pong frame buffers: tracks full
// buffers, drains them strictly alternating 0,1,0,1..., releases them back
// to the inflow side, and reports overrun/timeout errors and a frame count.
module outflow_ctrl
  import outflow_ctrl_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 0,
  parameter int CNT_W          = 32
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             inflow_done0,
  input  logic             inflow_done1,
  output logic             drain_start,
  output logic             drain_sel,
  input  logic             drain_done,
  output logic             drain_abort,
  output logic             buf_release0,
  output logic             buf_release1,
  output logic [1:0]       ready_flags,
  output logic             busy,
  output logic [CNT_W-1:0] drained_frames,
  output logic             overrun_err,
  output logic             timeout_err,
  input  logic             clr_err
);

  logic [0:0]       state_q,   state_d;
  logic [1:0]       ready_q,   ready_d;
  logic             next_sel_q, next_sel_d;
  logic             drain_sel_q, drain_sel_d;
  logic             start_q,   start_d;
  logic             abort_q,   abort_d;
  logic [1:0]       release_q, release_d;
  logic [CNT_W-1:0] cnt_q,     cnt_d;
  logic             overrun_q, overrun_d;
  logic             timeout_q, timeout_d;
  logic             busy_s;
  logic             tc_s;
  logic             ov_ev_s;
  logic             to_ev_s;
  logic [1:0]       done_in_s;

  assign busy_s    = (state_q == S_DRAIN);
  assign done_in_s = {inflow_done1, inflow_done0};

  outflow_ctrl_drain_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_drain_timer (
    .clk    (clk),
    .resetn (resetn),
    .load_i (start_d),
    .en_i   (busy_s),
    .tc_o   (tc_s)
  );

  // Sequencer next-state: start in order, finish on done or timeout
  always_comb begin
    state_d     = state_q;
    ready_d     = ready_q | done_in_s;
    next_sel_d  = next_sel_q;
    drain_sel_d = drain_sel_q;
    start_d     = 1'b0;
    abort_d     = 1'b0;
    release_d   = 2'b00;
    cnt_d       = cnt_q;
    to_ev_s     = 1'b0;
    // A completion in the same cycle still counts as an overrun; the clear
    // below then wins and the late frame is lost.
    ov_ev_s     = |(done_in_s & ready_q);
    case (state_q)
      S_IDLE: begin
        if (enable && ready_q[next_sel_q]) begin
          drain_sel_d = next_sel_q;
          start_d     = 1'b1;
          state_d     = S_DRAIN;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_DRAIN: begin
        if (drain_done) begin
          release_d  = buf_onehot(drain_sel_q);
          ready_d    = ready_d & ~buf_onehot(drain_sel_q);
          next_sel_d = ~drain_sel_q;
          cnt_d      = cnt_q + CNT_W'(1);
          state_d    = S_IDLE;
        end else if (tc_s) begin
          abort_d    = 1'b1;
          to_ev_s    = 1'b1;
          release_d  = buf_onehot(drain_sel_q);
          ready_d    = ready_d & ~buf_onehot(drain_sel_q);
          next_sel_d = ~drain_sel_q;
          state_d    = S_IDLE;
        end else begin
          state_d = S_DRAIN;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // New error events dominate a simultaneous clear
    overrun_d = ov_ev_s | (overrun_q & ~clr_err);
    timeout_d = to_ev_s | (timeout_q & ~clr_err);
  end

  // State and output registers; reset abandons any drain without pulses
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= S_IDLE;
      ready_q     <= 2'b00;
      next_sel_q  <= BUF0;
      drain_sel_q <= BUF0;
      start_q     <= 1'b0;
      abort_q     <= 1'b0;
      release_q   <= 2'b00;
      cnt_q       <= {CNT_W{1'b0}};
      overrun_q   <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ready_q     <= ready_d;
      next_sel_q  <= next_sel_d;
      drain_sel_q <= drain_sel_d;
      start_q     <= start_d;
      abort_q     <= abort_d;
      release_q   <= release_d;
      cnt_q       <= cnt_d;
      overrun_q   <= overrun_d;
      timeout_q   <= timeout_d;
    end
  end

  assign drain_start    = start_q;
  assign drain_sel      = drain_sel_q;
  assign drain_abort    = abort_q;
  assign buf_release0   = release_q[0];
  assign buf_release1   = release_q[1];
  assign ready_flags    = ready_q;
  assign busy           = busy_s;
  assign drained_frames = cnt_q;
  assign overrun_err    = overrun_q;
  assign timeout_err    = timeout_q;

endmodule

// File: tb/tb_outflow_ctrl.sv
// Self-checking bench for outflow_ctrl: a per-cycle vector table followed by
// hand-written multi-cycle sequences (alternation, ordering, timeout,
// enable gating, reset mid-drain).
module tb_outflow_ctrl;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       enable = 1'b0;
  logic       inflow_done0 = 1'b0;
  logic       inflow_done1 = 1'b0;
  logic       drain_done = 1'b0;
  logic       clr_err = 1'b0;
  logic       drain_start, drain_sel, drain_abort;
  logic       buf_release0, buf_release1, busy;
  logic [1:0] ready_flags;
  logic [7:0] drained_frames;
  logic       overrun_err, timeout_err;

  int cmp_cnt = 0;
  int err_cnt = 0;

  // {start, sel, abort, rel1, rel0, ready[1:0], busy, overrun, timeout}
  logic [9:0] obs_s;
  assign obs_s = {drain_start, drain_sel, drain_abort, buf_release1, buf_release0,
                  ready_flags, busy, overrun_err, timeout_err};

  typedef struct packed {
    logic       rstn;
    logic       en;
    logic       d0;
    logic       d1;
    logic       dd;
    logic       clr;
    logic [9:0] exp_o;
    logic [7:0] exp_cnt;
  } vec_t;

  vec_t vecs [21];

  outflow_ctrl #(
    .TIMEOUT_CYCLES(16),
    .CNT_W(8)
  ) dut (
    .clk            (clk),
    .resetn         (resetn),
    .enable         (enable),
    .inflow_done0   (inflow_done0),
    .inflow_done1   (inflow_done1),
    .drain_start    (drain_start),
    .drain_sel      (drain_sel),
    .drain_done     (drain_done),
    .drain_abort    (drain_abort),
    .buf_release0   (buf_release0),
    .buf_release1   (buf_release1),
    .ready_flags    (ready_flags),
    .busy           (busy),
    .drained_frames (drained_frames),
    .overrun_err    (overrun_err),
    .timeout_err    (timeout_err),
    .clr_err        (clr_err)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic [5:0] in_v, input logic [9:0] o, input logic [7:0] n);
    mk = {in_v, o, n};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    cmp_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic do_reset();
    resetn = 1'b0;
    enable = 1'b0;
    inflow_done0 = 1'b0;
    inflow_done1 = 1'b0;
    drain_done = 1'b0;
    clr_err = 1'b0;
    step();
    resetn = 1'b1;
  endtask

  task automatic pulse_in(input logic a, input logic b);
    inflow_done0 = a;
    inflow_done1 = b;
    step();
    inflow_done0 = 1'b0;
    inflow_done1 = 1'b0;
  endtask

  task automatic done_pulse();
    drain_done = 1'b1;
    step();
    drain_done = 1'b0;
  endtask

  initial begin
    int n;
    int starts;
    int evs;

    // inputs {rstn,en,d0,d1,dd,clr}; outputs after the sampling edge
    vecs[0]  = mk(6'b000000, 10'b0000000000, 8'd0);
    vecs[1]  = mk(6'b101000, 10'b0000001000, 8'd0);
    vecs[2]  = mk(6'b101000, 10'b0000001010, 8'd0);
    vecs[3]  = mk(6'b100001, 10'b0000001000, 8'd0);
    vecs[4]  = mk(6'b101001, 10'b0000001010, 8'd0);
    vecs[5]  = mk(6'b100001, 10'b0000001000, 8'd0);
    vecs[6]  = mk(6'b100100, 10'b0000011000, 8'd0);
    vecs[7]  = mk(6'b110000, 10'b1000011100, 8'd0);
    vecs[8]  = mk(6'b100000, 10'b0000011100, 8'd0);
    vecs[9]  = mk(6'b100010, 10'b0000110000, 8'd1);
    vecs[10] = mk(6'b100000, 10'b0000010000, 8'd1);
    vecs[11] = mk(6'b100010, 10'b0000010000, 8'd1);
    vecs[12] = mk(6'b110000, 10'b1100010100, 8'd1);
    vecs[13] = mk(6'b110100, 10'b0100010110, 8'd1);
    vecs[14] = mk(6'b110110, 10'b0101000010, 8'd2);
    vecs[15] = mk(6'b110001, 10'b0100000000, 8'd2);
    vecs[16] = mk(6'b111100, 10'b0100011000, 8'd2);
    vecs[17] = mk(6'b110000, 10'b1000011100, 8'd2);
    vecs[18] = mk(6'b110010, 10'b0000110000, 8'd3);
    vecs[19] = mk(6'b110000, 10'b1100010100, 8'd3);
    vecs[20] = mk(6'b110010, 10'b0101000000, 8'd4);

    #2;
    for (int i = 0; i < 21; i++) begin
      {resetn, enable, inflow_done0, inflow_done1, drain_done, clr_err} =
        {vecs[i].rstn, vecs[i].en, vecs[i].d0, vecs[i].d1, vecs[i].dd, vecs[i].clr};
      step();
      chk($sformatf("vec%0d", i), {14'd0, obs_s, drained_frames},
          {14'd0, vecs[i].exp_o, vecs[i].exp_cnt});
    end

    // Basic alternation: start 2 cycles after fill, drains 0 then 1
    do_reset();
    enable = 1'b1;
    pulse_in(1'b1, 1'b0);
    chk("alt_ready0", {drain_start, ready_flags}, 3'b001);
    step();
    chk("alt_start0", {drain_start, drain_sel, busy}, 3'b101);
    step();
    pulse_in(1'b0, 1'b1);
    chk("alt_ready11", ready_flags, 2'b11);
    repeat (7) step();
    done_pulse();
    chk("alt_rel0", {buf_release0, buf_release1, ready_flags, drained_frames}, {4'b1010, 8'd1});
    step();
    chk("alt_start1", {drain_start, drain_sel, busy}, 3'b111);
    repeat (9) step();
    done_pulse();
    chk("alt_rel1", {buf_release0, buf_release1, ready_flags, drained_frames}, {4'b0100, 8'd2});
    step();
    chk("alt_idle", {drain_start, busy}, 2'b00);

    // Out-of-order hold: buffer 1 waits for buffer 0
    do_reset();
    enable = 1'b1;
    pulse_in(1'b0, 1'b1);
    starts = 0;
    repeat (50) begin
      step();
      if (drain_start) starts++;
    end
    chk("ooo_nostart", starts, 0);
    chk("ooo_ready", ready_flags, 2'b10);
    pulse_in(1'b1, 1'b0);
    step();
    chk("ooo_start0", {drain_start, drain_sel}, 2'b10);
    repeat (3) step();
    done_pulse();
    chk("ooo_rel0", {buf_release0, buf_release1, ready_flags}, 4'b1010);
    step();
    chk("ooo_start1", {drain_start, drain_sel}, 2'b11);
    repeat (3) step();
    done_pulse();
    chk("ooo_rel1", {buf_release0, buf_release1, ready_flags}, 4'b0100);

    // Timeout: abort 16 cycles after drain_start, no count, next is buffer 1
    do_reset();
    enable = 1'b1;
    pulse_in(1'b1, 1'b0);
    step();
    chk("to_start0", {drain_start, drain_sel}, 2'b10);
    n = 0;
    while (drain_abort !== 1'b1 && n < 40) begin
      step();
      n++;
    end
    chk("to_cycles", n, 16);
    chk("to_abort", {drain_abort, buf_release0, buf_release1, timeout_err, busy, ready_flags},
        7'b1101000);
    chk("to_cnt", drained_frames, 8'd0);
    step();
    chk("to_pulse_len", {drain_abort, buf_release0, timeout_err}, 3'b001);
    pulse_in(1'b1, 1'b1);
    step();
    chk("to_next", {drain_start, drain_sel, timeout_err}, 3'b111);
    done_pulse();
    clr_err = 1'b1;
    step();
    clr_err = 1'b0;
    chk("to_clr", {timeout_err, drained_frames}, {1'b0, 8'd1});

    // Enable gating: no start while low, in-flight drain completes
    do_reset();
    pulse_in(1'b1, 1'b1);
    starts = 0;
    repeat (5) begin
      step();
      if (drain_start) starts++;
    end
    chk("en_nostart", starts, 0);
    enable = 1'b1;
    step();
    chk("en_start0", {drain_start, drain_sel}, 2'b10);
    step();
    enable = 1'b0;
    repeat (3) step();
    done_pulse();
    chk("en_rel0", {buf_release0, buf_release1, ready_flags}, 4'b1010);
    starts = 0;
    repeat (10) begin
      step();
      if (drain_start || busy) starts++;
    end
    chk("en_hold", starts, 0);
    enable = 1'b1;
    step();
    chk("en_start1", {drain_start, drain_sel}, 2'b11);
    done_pulse();
    chk("en_rel1", {buf_release1, ready_flags, drained_frames}, {3'b100, 8'd2});

    // Reset mid-drain of buffer 1: silent abandon, next drain is buffer 0
    do_reset();
    enable = 1'b1;
    pulse_in(1'b1, 1'b0);
    step();
    repeat (2) step();
    done_pulse();
    pulse_in(1'b0, 1'b1);
    step();
    chk("rst_pre", {drain_start, drain_sel}, 2'b11);
    repeat (3) step();
    resetn = 1'b0;
    step();
    chk("rst_out", {obs_s, drained_frames}, 18'd0);
    resetn = 1'b1;
    evs = 0;
    repeat (20) begin
      step();
      if (drain_abort || buf_release0 || buf_release1 || drain_start) evs++;
    end
    chk("rst_quiet", {evs[7:0], ready_flags, busy}, 11'd0);
    pulse_in(1'b1, 1'b1);
    step();
    chk("rst_next", {drain_start, drain_sel}, 2'b10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/outflow_ctrl.md
Name: outflow_ctrl

Overview:
- Drain-side sequencer for the two ping-pong QSFP frame buffers. The inflow switch controller alternates filling between the two buffers.
- This block records which buffers hold a complete frame and drains them to the downstream (PCIe/host) engine in strict alternating order, 0,1,0,1...
- When a drain completes, it releases the buffer back to the inflow side.
- It also enforces a drain timeout and reports overrun/timeout errors and a drained-frame count.

Parameters:
- TIMEOUT_CYCLES, 0, max cycles in DRAIN before abort; 0 disables the timeout.
- CNT_W, 32, width of drained_frames counter.

Ports:
- clk  in  1  clock
- resetn  in  1  synchronous, active-low reset
- enable  in  1  permits new drains to start; does not affect an in-progress drain
- inflow_done0  in  1  one-cycle pulse: buffer 0 holds a complete frame
- inflow_done1  in  1  one-cycle pulse: buffer 1 holds a complete frame
- drain_start  out  1  one-cycle pulse: begin draining buffer drain_sel
- drain_sel  out  1  buffer being drained; stable from drain_start through drain_done/abort
- drain_done  in  1  one-cycle pulse from drain engine: drain complete
- drain_abort  out  1  one-cycle pulse: drain timed out, engine must stop
- buf_release0  out  1  one-cycle pulse: buffer 0 is empty and may refill
- buf_release1  out  1  one-cycle pulse: buffer 1 is empty and may refill
- ready_flags  out  2  bit i = buffer i full and awaiting drain
- busy  out  1  high while in DRAIN state
- drained_frames  out  CNT_W  count of successful drains; wraps modulo 2^CNT_W
- overrun_err  out  1  sticky: inflow_done on a buffer already full or draining
- timeout_err  out  1  sticky: drain aborted by timeout
- clr_err  in  1  clears both sticky errors

Behaviour:
- Reset (resetn=0 at an edge): all outputs 0, ready_flags=0, next_sel=0, state IDLE, timer 0. Reset mid-drain abandons the drain silently: no abort and no release pulse.
- ready[i] set: set on inflow_done_i.
- ready[i] clear: cleared at the edge where the drain of buffer i completes or aborts.
- next_sel: internal; the buffer that must drain next. It toggles after every completed or aborted drain.
- State IDLE:
  - If enable && ready[next_sel]: drain_sel<=next_sel, drain_start<=1 for one cycle, timer<=0, go DRAIN.
  - A ready buffer other than next_sel is never drained out of order; it waits.
- State DRAIN:
  - busy=1; timer increments each cycle, saturating.
  - On drain_done: pulse buf_release[drain_sel], clear ready[drain_sel], next_sel<=~drain_sel, drained_frames++, go IDLE.
  - If TIMEOUT_CYCLES!=0 && timer==TIMEOUT_CYCLES-1 without drain_done: pulse drain_abort, pulse buf_release[drain_sel], clear ready, toggle next_sel, set timeout_err, go IDLE. drained_frames is not incremented.
  - drain_done in the same cycle as timeout: drain_done wins (normal completion).
- drain_done while in IDLE is ignored; no error.
- Latency:
  - inflow_done sampled at edge k means ready visible after k; drain_start is high during the cycle after edge k+1, i.e. 2 cycles after the pulse.
  - drain_done sampled at edge m means release pulse after m. The next drain_start is earliest after edge m+1, so there is one idle cycle minimum between drains.
- Overrun: inflow_done_i while ready[i]=1 sets overrun_err; ready[i] stays 1.
  - This includes the completion cycle of buffer i. Clear takes priority there, so ready[i] ends 0 and the frame is counted as lost.
- Simultaneous inflow_done0 and inflow_done1: both flags are set independently; the drain order remains next_sel-first.
- clr_err and a new error event in the same cycle: the error wins (stays set).
- enable deasserted in DRAIN: the current drain finishes normally; no new start until enable=1.

Decomposition:
- Shared package holds:
  - FSM state encoding (S_IDLE, S_DRAIN);
  - buffer-index constants BUF0=0, BUF1=1.
- One natural sub-module: drain_timer (loadable saturating counter with terminal-count compare, disabled when TIMEOUT_CYCLES=0).
- All else is inline in outflow_ctrl.

Test Plan:
- Basic alternation: pulse inflow_done0, then inflow_done1 3 cycles later; drain_done 10 cycles after each start. Expect:
  - drain_start with drain_sel=0 two cycles after the first pulse;
  - buf_release0, then drain_sel=1 start one cycle after release;
  - buf_release1 and drained_frames=2.
- Out-of-order hold: after reset, pulse inflow_done1 only. Expect no drain_start for 50 cycles and ready_flags=2'b10. Then pulse inflow_done0: buffer 0 drains first, then buffer 1.
- Timeout: TIMEOUT_CYCLES=16, fill buffer 0, never send drain_done. Expect:
  - drain_abort and buf_release0 together on the 16th DRAIN cycle;
  - timeout_err=1, drained_frames=0, next drain targets buffer 1.
- Overrun: pulse inflow_done0 twice without a drain (enable=0). Expect overrun_err=1 and ready_flags=2'b01. Pulse clr_err: overrun_err=0.
- Enable gating: enable=0 with both buffers ready, so no start. Raise enable and drop it 1 cycle after drain_start. Expect the current drain to complete with release0, and no further start until enable returns.
- Reset mid-drain: assert resetn=0 during DRAIN. Expect all outputs 0, no release or abort pulse, and the next drain after reset targets buffer 0.
